// File: rtl/ha_cnt_pkg.sv
// Shared encodings and default sizing for the half-adder based counter.
package ha_cnt_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH = 9;
  localparam int unsigned DEF_PSW   = 4;

endpackage

// File: rtl/ha_inc.sv
// Ripple half-adder incrementer: s = a + ci, co is the carry out of the MSB.
module ha_inc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ c[i];
      c[i+1] = a[i] & c[i];
    end
    co = c[WIDTH];
  end

endmodule

// File: rtl/ha_counter.sv
// Up/down counter with prescaler, wrap/saturate terminal handling and load.
module ha_counter
  import ha_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned PSW   = DEF_PSW
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ci,
  input  logic             up,
  input  logic             sat,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PSW-1:0]   div,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  logic [PSW-1:0]   pc;
  logic [PSW-1:0]   pc_inc;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_neg;
  logic [WIDTH-1:0] q_step;
  logic             dn_co;
  logic             term;
  logic             unused_up_co;
  logic             unused_pc_co;

  ha_inc #(.WIDTH(WIDTH)) u_up (
    .a  (q),
    .ci (1'b1),
    .s  (q_inc),
    .co (unused_up_co)
  );

  // q-1 is formed as ~(~q + 1); the carry out is set exactly when q == 0.
  ha_inc #(.WIDTH(WIDTH)) u_dn (
    .a  (~q),
    .ci (1'b1),
    .s  (q_neg),
    .co (dn_co)
  );

  ha_inc #(.WIDTH(PSW)) u_pc (
    .a  (pc),
    .ci (1'b1),
    .s  (pc_inc),
    .co (unused_pc_co)
  );

  always_comb begin
    q_step = q;
    term   = 1'b0;
    if (dir_e'(up) == DIR_UP) begin
      if (q < limit) begin
        q_step = q_inc;
      end else begin
        term   = 1'b1;
        q_step = (mode_e'(sat) == MODE_SAT) ? q : '0;
      end
    end else begin
      if (!dn_co) begin
        q_step = ~q_neg;
      end else begin
        term   = 1'b1;
        q_step = (mode_e'(sat) == MODE_SAT) ? '0 : limit;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      q  <= '0;
      pc <= '0;
      tc <= 1'b0;
    end else if (ld) begin
      q  <= ld_val;
      pc <= '0;
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (en && ci) begin
        if (pc == div) begin
          pc <= '0;
          q  <= q_step;
          tc <= term;
        end else begin
          pc <= pc_inc;
        end
      end
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_ha_counter.sv
// Directed scenarios plus randomized traffic against an integer reference model.
module tb_ha_counter;

  localparam int unsigned W = 9;
  localparam int unsigned P = 4;

  logic         sys_clk;
  logic         reset, en, ci, up, sat, ld;
  logic [W-1:0] ld_val, limit;
  logic [P-1:0] div;
  logic [W-1:0] q;
  logic         tc, zero;

  int n_checks = 0;
  int n_fail   = 0;

  int mq  = 0;
  int mpc = 0;
  int mtc = 0;

  ha_counter #(.WIDTH(W), .PSW(P)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .en      (en),
    .ci      (ci),
    .up      (up),
    .sat     (sat),
    .ld      (ld),
    .ld_val  (ld_val),
    .limit   (limit),
    .div     (div),
    .q       (q),
    .tc      (tc),
    .zero    (zero)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare on the falling edge.
  task automatic drive(input bit r, input bit e, input bit c, input bit u, input bit s,
                       input bit l, input int lv, input int lim, input int d);
    reset  = r;
    en     = e;
    ci     = c;
    up     = u;
    sat    = s;
    ld     = l;
    ld_val = lv[W-1:0];
    limit  = lim[W-1:0];
    div    = d[P-1:0];
    @(posedge sys_clk);
    mtc = 0;
    if (r) begin
      mq  = 0;
      mpc = 0;
    end else if (l) begin
      mq  = lv % (1 << W);
      mpc = 0;
    end else if (e && c) begin
      if (mpc == d) begin
        mpc = 0;
        if (u) begin
          if (mq < lim) mq = mq + 1;
          else begin
            mtc = 1;
            if (!s) mq = 0;
          end
        end else begin
          if (mq > 0) mq = mq - 1;
          else begin
            mtc = 1;
            if (!s) mq = lim;
          end
        end
      end else begin
        mpc = (mpc + 1) % (1 << P);
      end
    end
    @(negedge sys_clk);
    check("q", 32'(q), 32'(mq));
    check("tc", 32'(tc), 32'(mtc));
    check("zero", 32'(zero), (mq == 0) ? 32'd1 : 32'd0);
  endtask

  int s38_q  [7] = '{1, 2, 3, 4, 5, 0, 1};
  int s38_tc [7] = '{0, 0, 0, 0, 0, 1, 0};
  int s39_q  [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
  int s40_tc [3] = '{0, 1, 1};

  initial begin
    reset = 1'b1; en = 1'b0; ci = 1'b0; up = 1'b1; sat = 1'b0; ld = 1'b0;
    ld_val = '0; limit = '0; div = '0;

    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);

    // Wrap at limit 5.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 1, 1, 0, 0, 0, 5, 0);
      check("s38_q", 32'(q), 32'(s38_q[i]));
      check("s38_tc", 32'(tc), 32'(s38_tc[i]));
    end

    // Prescale by 3.
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 1, 1, 0, 0, 0, 100, 2);
      check("s39_q", 32'(q), 32'(s39_q[i]));
    end

    // Saturating down count from 1.
    drive(0, 0, 0, 0, 1, 1, 1, 10, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 1, 0, 0, 10, 0);
      check("s40_q", 32'(q), 32'd0);
      check("s40_tc", 32'(tc), 32'(s40_tc[i]));
    end

    // Load overrides a same-cycle request, then wrap from the top.
    drive(0, 1, 1, 1, 0, 1, 'h1FF, 'h1FF, 0);
    check("s41_ld", 32'(q), 32'h1FF);
    drive(0, 1, 1, 1, 0, 0, 0, 'h1FF, 0);
    check("s41_q", 32'(q), 32'd0);
    check("s41_tc", 32'(tc), 32'd1);

    // Reset beats load mid-count and drops the partial prescale.
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 0, 0, 0, 50, 1);
    drive(1, 1, 1, 1, 0, 1, 'h0AA, 50, 1);
    check("s42_q", 32'(q), 32'd0);
    check("s42_tc", 32'(tc), 32'd0);
    drive(0, 1, 1, 1, 0, 0, 0, 50, 1);
    check("s42_pc", 32'(q), 32'd0);
    drive(0, 1, 1, 1, 0, 0, 0, 50, 1);
    check("s42_step", 32'(q), 32'd1);

    // Enable low freezes q and the prescaler; limit 0 makes every up step terminal.
    drive(0, 1, 1, 1, 0, 0, 0, 50, 3);
    drive(0, 1, 1, 1, 0, 0, 0, 50, 3);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, i[0], 1, 0, 0, 0, 50, 3);
      check("s43_q", 32'(q), 32'd1);
      check("s43_tc", 32'(tc), 32'd0);
    end
    drive(0, 1, 1, 1, 0, 0, 0, 50, 3);
    check("s43_hold", 32'(q), 32'd1);
    drive(0, 1, 1, 1, 0, 0, 0, 50, 3);
    check("s43_step", 32'(q), 32'd2);

    drive(0, 0, 0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
    check("lim0_q", 32'(q), 32'd0);
    check("lim0_tc", 32'(tc), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      bit r, e, c, u, s, l;
      int lv, lim, d;
      r   = ($urandom_range(0, 63) == 0);
      l   = ($urandom_range(0, 31) == 0);
      e   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 3) != 0);
      u   = ($urandom_range(0, 7) != 0) ? up : ~up;
      s   = ($urandom_range(0, 15) != 0) ? sat : ~sat;
      lv  = $urandom_range(0, 511);
      lim = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12) : $urandom_range(0, 511);
      d   = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
      drive(r, e, c, u, s, l, lv, lim, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ha_counter.md
HA_COUNTER -- requirements
Module: ha_counter

Interface
REQ-001 Parameter WIDTH, default 9: counter width in bits, legal range 2..32.
REQ-002 Parameter PSW, default 4: prescaler width in bits, legal range 1..8.
REQ-003 Port sys_clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: reset is synchronous and active-high.
REQ-005 Port en  input  1: global enable; when 0, count and prescaler both hold.
REQ-006 Port ci  input  1: count request, qualified by en.
REQ-007 Port up  input  1: direction; 1 = increment, 0 = decrement.
REQ-008 Port sat  input  1: terminal mode; 0 = wrap, 1 = saturate.
REQ-009 Port ld  input  1: synchronous load strobe.
REQ-010 Port ld_val  input  WIDTH: value to load.
REQ-011 Port limit  input  WIDTH: terminal value for up-counting and wrap target for down-counting.
REQ-012 Port div  input  PSW: prescale divisor; the count steps once per div+1 qualified requests.
REQ-013 Port q  output  WIDTH: registered count value.
REQ-014 Port tc  output  1: registered terminal-count pulse.
REQ-015 Port zero  output  1: combinational flag, q == 0.

Function
REQ-016 A qualified request is en=1 and ci=1 in the same cycle; all other cycles leave q and the prescaler unchanged.
REQ-017 Prescaler pc (PSW bits): on a qualified request, if pc == div then pc<=0 and a step occurs, else pc<=pc+1 with no step.
REQ-018 div=0 gives a step on every qualified request.
REQ-019 Up step with q < limit: q<=q+1.
REQ-020 Up step with q >= limit: q<=0 if sat=0, or q<=q (hold) if sat=1; tc<=1 in both cases.
REQ-021 Down step with q > 0: q<=q-1.
REQ-022 Down step with q == 0: q<=limit if sat=0, or q<=0 if sat=1; tc<=1 in both cases.
REQ-023 tc is 1 for exactly the cycle after a terminal step and 0 in every other cycle; it asserts on every terminal step, including repeated steps while saturated.
REQ-024 Priority: reset > ld > step.
REQ-025 ld=1: q<=ld_val, pc<=0, tc<=0, regardless of en or ci; any request in the same cycle is discarded.
REQ-026 Latency: q and tc reflect a step one cycle after the qualifying edge.
REQ-027 Arithmetic is unsigned modulo 2^WIDTH; no internal overflow is observable.
REQ-028 limit and div are sampled every cycle; a change takes effect on the next step evaluation with no retiming.
REQ-029 limit=0 with up: every step is terminal (wrap mode holds q at 0).
REQ-030 Changing up mid-count does not reset pc.

Reset
REQ-031 On reset=1 at a clock edge: q<=0, pc<=0, tc<=0; zero=1 in the following cycle.
REQ-032 Reset overrides ld and ci in the same cycle; the counter resumes on the first edge after reset deasserts.
REQ-033 Reset mid-prescale discards the partial prescale count.

Structure
REQ-034 Shared package ha_cnt_pkg holds: the direction encodings (DIR_UP=1, DIR_DN=0), the mode encodings (MODE_WRAP=0, MODE_SAT=1), and the default WIDTH and PSW values.
REQ-035 Sub-module ha_inc, a parametrised WIDTH-bit combinational half-adder incrementer with carry-in and carry-out, is instantiated for both the up path and the prescaler.
REQ-036 The down path uses ha_inc on the inverted operand.
REQ-037 The only state is q, pc and tc; there is no other storage.

Verification
REQ-038 Scenario: WIDTH=9, div=0, up=1, sat=0, limit=5, ci held 7 cycles -> q sequence 1,2,3,4,5,0,1; tc=1 only in the cycle q becomes 0.
REQ-039 Scenario: div=2, up=1, ci held 9 cycles from q=0 -> q steps to 1,2,3 on the 3rd, 6th and 9th requests; no step on any other request.
REQ-040 Scenario: sat=1, up=0, q=1, ci held 3 cycles -> q = 0,0,0; tc=1 on the 2nd and 3rd results.
REQ-041 Scenario: ld=1 with ld_val=0x1FF and ci=1 in the same cycle, then up=1, limit=0x1FF, sat=0, one request -> q=0x1FF after the load, then q=0 with tc=1.
REQ-042 Scenario: reset=1 asserted together with ld=1, ld_val=0x0AA during a count -> q=0, pc=0, tc=0 on the next cycle.
REQ-043 Scenario: en=0 with ci toggling for 10 cycles -> q and pc unchanged; tc stays 0.
